pram_loader: RTL and testbench

//  Writer side of the 32x16 program RAM: receives a framed byte stream and writes 16-bit

---
 rtl/n1_pkg.sv | 33 +++
 rtl/pram_loader_if.sv | 35 +++
 rtl/pram_loader.sv | 156 +++++++++++++++
 tb/tb_pram_loader.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/n1_pkg.sv
// Shared definitions for the program-RAM loader: RAM geometry, frame marker,
// loader FSM state encoding and the LEN field decode.
package n1_pkg;

   localparam int          PRAM_ADDR_W = 5;
   localparam int          PRAM_WORD_W = 16;
   localparam int          PRAM_DEPTH  = 1 << PRAM_ADDR_W;
   localparam logic [7:0]  SYNC_BYTE   = 8'hA5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SYNC,
      ST_LEN,
      ST_LO,
      ST_HI,
      ST_CSUM,
      ST_DONE,
      ST_ERR
   } loader_state_t;

   // LEN=0 selects the full RAM; lengths beyond the RAM are clamped so
   // the write address can never run past the last word.
   function automatic logic [PRAM_ADDR_W:0] len_to_count(input logic [7:0] len);
      logic [PRAM_ADDR_W:0] count;
      if (len == 8'd0 || len > 8'(PRAM_DEPTH)) begin
         count = (PRAM_ADDR_W + 1)'(PRAM_DEPTH);
      end else begin
         count = len[PRAM_ADDR_W:0];
      end
      return count;
   endfunction

endpackage

// File: rtl/pram_loader_if.sv
// Byte-stream input and program-RAM write port of the loader.
// master = loader side, slave = stream source / RAM side.
interface pram_loader_if
   import n1_pkg::*;
#(
   parameter int ADDR_W = PRAM_ADDR_W,
   parameter int WORD_W = PRAM_WORD_W
);

   logic [7:0]        in_data;
   logic              in_valid;
   logic              in_ready;
   logic              pram_we;
   logic [ADDR_W-1:0] pram_addr;
   logic [WORD_W-1:0] pram_wdata;

   modport master (
      input  in_data,
      input  in_valid,
      output in_ready,
      output pram_we,
      output pram_addr,
      output pram_wdata
   );

   modport slave (
      output in_data,
      output in_valid,
      input  in_ready,
      input  pram_we,
      input  pram_addr,
      input  pram_wdata
   );

endinterface

// File: rtl/pram_loader.sv
// Program-RAM loader: parses SYNC,LEN,{lo,hi}*LEN,CSUM from a byte stream,
// writes words from address 0 upward and holds the core until a good frame lands.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | not armed, waiting for load_req
// ST_SYNC  | discarding bytes until SYNC_BYTE
// ST_LEN   | next byte is the word count
// ST_LO    | next byte is the low byte of word cnt
// ST_HI    | next byte is the high byte; write issued the following cycle
// ST_CSUM  | next byte is the XOR checksum of all data bytes
// ST_DONE  | frame loaded and checksum good, core released
// ST_ERR   | checksum bad, core kept in hold
module pram_loader
   import n1_pkg::*;
#(
   parameter int         ADDR_W    = PRAM_ADDR_W,
   parameter logic [7:0] SYNC_BYTE = n1_pkg::SYNC_BYTE
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load_req,
   pram_loader_if.master bus,
   output logic          cpu_hold,
   output logic          done,
   output logic          err
);

   localparam int CNT_W = ADDR_W + 1;

   loader_state_t     state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [7:0]        csum_q, csum_d;
   logic [7:0]        lo_q, lo_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [15:0]       wdata_q, wdata_d;
   logic              hold_q, hold_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

   logic              in_ready;
   logic              xfer;
   logic [CNT_W-1:0]  cnt_inc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         count_q <= '0;
         csum_q  <= 8'h00;
         lo_q    <= 8'h00;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= 16'h0000;
         hold_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         count_q <= count_d;
         csum_q  <= csum_d;
         lo_q    <= lo_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         hold_q  <= hold_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      in_ready = 1'b0;
      case (state_q)
         ST_SYNC, ST_LEN, ST_LO, ST_HI, ST_CSUM: in_ready = 1'b1;
         default:                                in_ready = 1'b0;
      endcase
   end

   // A byte presented together with load_req is dropped: the restart wins.
   assign xfer    = bus.in_valid & in_ready & ~load_req;
   assign cnt_inc = cnt_q + CNT_W'(1);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      count_d = count_q;
      csum_d  = csum_q;
      lo_d    = lo_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      hold_d  = hold_q;
      done_d  = done_q;
      err_d   = err_q;

      if (load_req) begin
         state_d = ST_SYNC;
         cnt_d   = '0;
         csum_d  = 8'h00;
         hold_d  = 1'b1;
         done_d  = 1'b0;
         err_d   = 1'b0;
      end else if (xfer) begin
         case (state_q)
            ST_SYNC: begin
               if (bus.in_data == SYNC_BYTE) begin
                  state_d = ST_LEN;
               end
            end
            ST_LEN: begin
               count_d = len_to_count(bus.in_data);
               cnt_d   = '0;
               csum_d  = 8'h00;
               state_d = ST_LO;
            end
            ST_LO: begin
               lo_d    = bus.in_data;
               csum_d  = csum_q ^ bus.in_data;
               state_d = ST_HI;
            end
            ST_HI: begin
               csum_d  = csum_q ^ bus.in_data;
               we_d    = 1'b1;
               addr_d  = cnt_q[ADDR_W-1:0];
               wdata_d = {bus.in_data, lo_q};
               cnt_d   = cnt_inc;
               state_d = (cnt_inc == count_q) ? ST_CSUM : ST_LO;
            end
            ST_CSUM: begin
               if (bus.in_data == csum_q) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
                  hold_d  = 1'b0;
               end else begin
                  state_d = ST_ERR;
                  err_d   = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready   = in_ready;
   assign bus.pram_we    = we_q;
   assign bus.pram_addr  = addr_q;
   assign bus.pram_wdata = wdata_q;
   assign cpu_hold       = hold_q;
   assign done           = done_q;
   assign err            = err_q;

endmodule

// File: tb/tb_pram_loader.sv
// Directed bench for pram_loader: frames, bad checksum, noise, full-depth load,
// restart mid-frame and asynchronous reset mid-word.
module tb_pram_loader;
   import n1_pkg::*;

   logic clk    = 1'b0;
   logic rst_n  = 1'b0;
   logic load_req = 1'b0;
   logic cpu_hold, done, err;

   pram_loader_if bus ();

   pram_loader dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .load_req (load_req),
      .bus      (bus.master),
      .cpu_hold (cpu_hold),
      .done     (done),
      .err      (err)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // write log captured mid-cycle
   int         wn = 0;
   logic [4:0] wa [0:127];
   logic [15:0] wd [0:127];
   int         wc [0:127];
   always @(negedge clk) begin
      if (bus.pram_we === 1'b1) begin
         if (wn < 128) begin
            wa[wn] = bus.pram_addr;
            wd[wn] = bus.pram_wdata;
            wc[wn] = cyc;
         end
         wn = wn + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // called just after a rising edge; leaves valid asserted for one edge
   task automatic send(input logic [7:0] b);
      bus.in_data  = b;
      bus.in_valid = 1'b1;
      if (bus.in_ready !== 1'b1) check("in_ready_on_send", bus.in_ready, 1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic pulse_load();
      load_req = 1'b1;
      @(posedge clk);
      #1;
      load_req = 1'b0;
   endtask

   task automatic check_reset_outputs(input string pfx);
      check({pfx, "_in_ready"}, bus.in_ready, 0);
      check({pfx, "_pram_we"}, bus.pram_we, 0);
      check({pfx, "_pram_addr"}, bus.pram_addr, 0);
      check({pfx, "_pram_wdata"}, bus.pram_wdata, 0);
      check({pfx, "_cpu_hold"}, cpu_hold, 0);
      check({pfx, "_done"}, done, 0);
      check({pfx, "_err"}, err, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int bad_addr, bad_data, bad_gap;
      logic [7:0] cs;
      logic [7:0] lo, hi;

      bus.in_data  = 8'h00;
      bus.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("rst");
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 1) good two-word frame
      base = wn;
      pulse_load();
      check("t1_hold_set", cpu_hold, 1);
      check("t1_ready_sync", bus.in_ready, 1);
      send(8'hA5); send(8'h02); send(8'h34); send(8'h12); send(8'h78); send(8'h56);
      check("t1_no_done_before_csum", done, 0);
      send(8'h08);
      check("t1_nwrites", wn - base, 2);
      check("t1_addr0", wa[base], 0);
      check("t1_data0", wd[base], 16'h1234);
      check("t1_addr1", wa[base+1], 1);
      check("t1_data1", wd[base+1], 16'h5678);
      check("t1_done", done, 1);
      check("t1_err", err, 0);
      check("t1_hold_clr", cpu_hold, 0);
      check("t1_ready_off", bus.in_ready, 0);

      // 2) same frame, bad checksum
      base = wn;
      pulse_load();
      check("t2_done_clr", done, 0);
      send(8'hA5); send(8'h02); send(8'h34); send(8'h12); send(8'h78); send(8'h56);
      send(8'h09);
      check("t2_nwrites", wn - base, 2);
      check("t2_data1", wd[base+1], 16'h5678);
      check("t2_err", err, 1);
      check("t2_done", done, 0);
      check("t2_hold", cpu_hold, 1);
      check("t2_ready_off", bus.in_ready, 0);

      // 3) noise before the sync byte
      base = wn;
      pulse_load();
      check("t3_err_clr", err, 0);
      send(8'h00); send(8'hFF); send(8'h5A);
      check("t3_noise_nowrite", wn - base, 0);
      check("t3_still_sync", bus.in_ready, 1);
      send(8'hA5); send(8'h01); send(8'hCD);
      check("t3_lo_nowrite", wn - base, 0);
      send(8'hAB);
      send(8'h66);
      check("t3_nwrites", wn - base, 1);
      check("t3_addr", wa[base], 0);
      check("t3_data", wd[base], 16'hABCD);
      check("t3_done", done, 1);

      // 4) LEN=0: full 32-word load, back-to-back bytes
      base = wn;
      cs = 8'h00;
      pulse_load();
      send(8'hA5); send(8'h00);
      for (int k = 0; k < 32; k++) begin
         lo = 8'(k * 7 + 3);
         hi = 8'(k ^ 8'h5C);
         cs = cs ^ lo ^ hi;
         send(lo);
         send(hi);
      end
      send(cs);
      bad_addr = 0; bad_data = 0; bad_gap = 0;
      for (int k = 0; k < 32; k++) begin
         lo = 8'(k * 7 + 3);
         hi = 8'(k ^ 8'h5C);
         if (wa[base+k] !== 5'(k)) bad_addr++;
         if (wd[base+k] !== {hi, lo}) bad_data++;
         if (k > 0 && (wc[base+k] - wc[base+k-1]) != 2) bad_gap++;
      end
      check("t4_nwrites", wn - base, 32);
      check("t4_bad_addr", bad_addr, 0);
      check("t4_bad_data", bad_data, 0);
      check("t4_bad_gap", bad_gap, 0);
      check("t4_last_addr", wa[base+31], 31);
      check("t4_done", done, 1);
      check("t4_hold", cpu_hold, 0);

      // 5) restart after first word of a 3-word frame, with a colliding byte
      base = wn;
      pulse_load();
      send(8'hA5); send(8'h03); send(8'h11); send(8'h22);
      load_req     = 1'b1;
      bus.in_data  = 8'hA5;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      load_req     = 1'b0;
      bus.in_valid = 1'b0;
      check("t5_pending_write", wn - base, 1);
      check("t5_first_addr", wa[base], 0);
      check("t5_first_data", wd[base], 16'h2211);
      check("t5_in_sync", bus.in_ready, 1);
      check("t5_hold", cpu_hold, 1);
      send(8'hA5); send(8'h01); send(8'h44); send(8'h33); send(8'h77);
      check("t5_nwrites", wn - base, 2);
      check("t5_restart_addr", wa[base+1], 0);
      check("t5_restart_data", wd[base+1], 16'h3344);
      check("t5_done", done, 1);

      // 6) asynchronous reset while waiting for a high byte
      base = wn;
      pulse_load();
      send(8'hA5); send(8'h02); send(8'h55); send(8'h66); send(8'h77);
      check("t6_one_write", wn - base, 1);
      check("t6_wdata_before", bus.pram_wdata, 16'h6655);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("t6");
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      bus.in_data  = 8'h88;
      bus.in_valid = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      check("t6_no_write_after", wn - base, 1);
      check("t6_idle_ready", bus.in_ready, 0);
      check("t6_idle_hold", cpu_hold, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
